cp0_tlb_timer: RTL and testbench

Second-generation coprocessor-0 register file for the MIPS32r1 core.
- Generalised over TLB depth, ASID width and Count prescale.
- Adds a true decrementing Random register bounded by Wired.
- Adds an ERET path and EXL-nested exception semantics: EPC and BD are not overwritten while EXL=1.
- Adds a Cause.TI timer interrupt with correct clear-on-Compare-write.
- Sits between the decode/writeback stage, the exception unit and the TLB array.

---
 rtl/cp0_pkg.sv | 62 ++++++
 rtl/cp0_random_gen.sv | 32 +++
 rtl/cp0_tlb_timer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cp0_tlb_timer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 register file.
// Contents: CP0 register addresses as {reg[4:0],sel[2:0]}, Status/Cause bit
// positions, the 78-bit TLB entry layout exchanged with the TLB array, and
// the exception code enumeration.
package cp0_pkg;

    // {reg, sel} read/write addresses
    localparam logic [7:0] CP0_INDEX    = 8'h00;  // reg 0
    localparam logic [7:0] CP0_RANDOM   = 8'h08;  // reg 1
    localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;  // reg 2
    localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;  // reg 3
    localparam logic [7:0] CP0_CONTEXT  = 8'h20;  // reg 4
    localparam logic [7:0] CP0_WIRED    = 8'h30;  // reg 6
    localparam logic [7:0] CP0_BADVADDR = 8'h40;  // reg 8
    localparam logic [7:0] CP0_COUNT    = 8'h48;  // reg 9
    localparam logic [7:0] CP0_ENTRYHI  = 8'h50;  // reg 10
    localparam logic [7:0] CP0_COMPARE  = 8'h58;  // reg 11
    localparam logic [7:0] CP0_STATUS   = 8'h60;  // reg 12
    localparam logic [7:0] CP0_CAUSE    = 8'h68;  // reg 13
    localparam logic [7:0] CP0_EPC      = 8'h70;  // reg 14
    localparam logic [7:0] CP0_PRID     = 8'h78;  // reg 15
    localparam logic [7:0] CP0_CONFIG   = 8'h80;  // reg 16 sel 0
    localparam logic [7:0] CP0_CONFIG1  = 8'h81;  // reg 16 sel 1

    // Status bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;

    // Status: software-writable bits are CU0, BEV, IM, UM, ERL, EXL, IE
    localparam logic [31:0] STATUS_WMASK = 32'h1040_FF17;
    localparam logic [31:0] STATUS_RESET = 32'h1040_0004;

    // Cause bit positions
    localparam int CA_IV = 23;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [24:0] lo0;   // {PFN0[19:0], C0[2:0], D0, V0}
        logic [24:0] lo1;   // {PFN1[19:0], C1[2:0], D1, V1}
    } tlb_entry_t;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

endpackage

// File: rtl/cp0_random_gen.sv
// CP0 Random register generator.
// Decrements every cycle from TLB_ENTRIES-1 down to Wired, then reloads.
// Ports: clk, rst (sync, active-high); wired = current Wired value;
// wired_we = Wired is being written this cycle (forces reload);
// random = current Random value.
module cp0_random_gen #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            random <= TOP;
        end else if (wired_we || (wired >= TOP) || (random == wired)) begin
            // Wired at the top of the range pins Random to the top entry.
            random <= TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

endmodule

// File: rtl/cp0_tlb_timer.sv
// MIPS32r1 coprocessor-0 register file with TLB support registers, a
// decrementing Random, EXL-nested exceptions/ERET and the Count/Compare timer.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   hint               hardware interrupts, registered into Cause.IP[6:2]
//   raddr/rdata        combinational MFC0 read, address {reg,sel}
//   wen/waddr/wdata    MTC0 write, visible the following cycle
//   exp_*              exception commit (EPC, BD, ExcCode, BadVAddr)
//   eret               ERET commit
//   tlbr/tlbp          TLB read / probe commit; probe_miss, probe_index result
//   tlb_entry_in/out   78-bit entry to/from the TLB array
//   cp0_index, cp0_random, curr_asid, user_mode, kseg0_uncached, exl,
//   epc_address, int_pending   decoded state for the rest of the core
module cp0_tlb_timer
    import cp0_pkg::*;
#(
    parameter int          TLB_ENTRIES = 16,
    parameter int          IDX_W       = $clog2(TLB_ENTRIES),
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] PRID_VAL    = 32'h0001_8000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       hint,
    input  logic [7:0]       raddr,
    output logic [31:0]      rdata,
    input  logic             wen,
    input  logic [7:0]       waddr,
    input  logic [31:0]      wdata,
    input  logic             exp_en,
    input  logic [4:0]       exp_code,
    input  logic             exp_bd,
    input  logic [31:0]      exp_epc,
    input  logic             exp_badvaddr_en,
    input  logic [31:0]      exp_badvaddr,
    input  logic             eret,
    input  logic             tlbr,
    input  logic             tlbp,
    input  logic             probe_miss,
    input  logic [IDX_W-1:0] probe_index,
    input  logic [77:0]      tlb_entry_in,
    output logic [77:0]      tlb_entry_out,
    output logic [IDX_W-1:0] cp0_index,
    output logic [IDX_W-1:0] cp0_random,
    output logic [7:0]       curr_asid,
    output logic             user_mode,
    output logic             kseg0_uncached,
    output logic             exl,
    output logic [31:0]      epc_address,
    output logic             int_pending
);

    localparam int               PRE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIV - 1);

    // Architectural state
    logic             index_p;
    logic [IDX_W-1:0] index_val;
    logic [29:0]      entrylo0, entrylo1;
    logic [8:0]       ctx_pte;
    logic [18:0]      ctx_vpn2;
    logic [IDX_W-1:0] wired;
    logic [31:0]      badvaddr, count, compare, epc, status;
    logic [PRE_W-1:0] presc;
    logic [18:0]      hi_vpn2;
    logic [7:0]       hi_asid;
    logic             cause_bd, cause_ti, cause_iv;
    logic [1:0]       ip_sw;
    logic [4:0]       ip_hw;
    exc_code_e        exccode;
    logic [2:0]       k0;

    // MTC0 decode
    logic we_index, we_lo0, we_lo1, we_context, we_wired, we_count;
    logic we_entryhi, we_compare, we_status, we_cause, we_epc, we_config;
    assign we_index   = wen && (waddr == CP0_INDEX);
    assign we_lo0     = wen && (waddr == CP0_ENTRYLO0);
    assign we_lo1     = wen && (waddr == CP0_ENTRYLO1);
    assign we_context = wen && (waddr == CP0_CONTEXT);
    assign we_wired   = wen && (waddr == CP0_WIRED);
    assign we_count   = wen && (waddr == CP0_COUNT);
    assign we_entryhi = wen && (waddr == CP0_ENTRYHI);
    assign we_compare = wen && (waddr == CP0_COMPARE);
    assign we_status  = wen && (waddr == CP0_STATUS);
    assign we_cause   = wen && (waddr == CP0_CAUSE);
    assign we_epc     = wen && (waddr == CP0_EPC);
    assign we_config  = wen && (waddr == CP0_CONFIG);

    logic exp_bad;
    assign exp_bad = exp_en && exp_badvaddr_en;

    tlb_entry_t tin, tout;
    assign tin = tlb_entry_t'(tlb_entry_in);

    // Count tick and timer match; a Count write suppresses the increment.
    logic        tick, timer_match;
    logic [31:0] count_inc;
    assign tick        = (presc == PRE_LAST);
    assign count_inc   = count + 32'd1;
    assign timer_match = tick && !we_count && (count_inc == compare);

    // Status: lowest-priority source first so later lines override per field.
    logic [31:0] status_next;
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        status_next = status;
        if (we_status) status_next = wdata & STATUS_WMASK;
        if (eret) begin
            if (status[ST_ERL]) status_next[ST_ERL] = 1'b0;
            else                status_next[ST_EXL] = 1'b0;
        end
        if (exp_en) status_next[ST_EXL] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_p   <= 1'b0;
            index_val <= '0;
            entrylo0  <= '0;
            entrylo1  <= '0;
            ctx_pte   <= '0;
            ctx_vpn2  <= '0;
            wired     <= '0;
            badvaddr  <= '0;
            count     <= '0;
            presc     <= '0;
            compare   <= '0;
            hi_vpn2   <= '0;
            hi_asid   <= '0;
            status    <= STATUS_RESET;
            cause_bd  <= 1'b0;
            cause_ti  <= 1'b0;
            cause_iv  <= 1'b0;
            ip_sw     <= '0;
            ip_hw     <= '0;
            exccode   <= EXC_INT;
            epc       <= '0;
            k0        <= '0;
        end else begin
            status <= status_next;
            ip_hw  <= hint;

            if (we_count) begin
                count <= wdata;
                presc <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) count <= count_inc;
            end

            if (we_compare) begin
                compare  <= wdata;
                cause_ti <= 1'b0;       // clear wins over a same-cycle match
            end else if (timer_match) begin
                cause_ti <= 1'b1;
            end

            if (we_cause) begin
                cause_iv <= wdata[CA_IV];
                ip_sw    <= wdata[9:8];
            end

            // Nested exceptions keep the EPC/BD of the outermost one.
            if (exp_en) begin
                exccode <= exc_code_e'(exp_code);
                if (!status[ST_EXL]) begin
                    epc      <= exp_epc;
                    cause_bd <= exp_bd;
                end
            end else if (we_epc) begin
                epc <= wdata;
            end

            if (exp_bad) begin
                badvaddr <= exp_badvaddr;
                ctx_vpn2 <= exp_badvaddr[31:13];
            end
            if (we_context) ctx_pte <= wdata[31:23];

            if (exp_bad)         hi_vpn2 <= exp_badvaddr[31:13];
            else if (tlbr)       hi_vpn2 <= tin.vpn2;
            else if (we_entryhi) hi_vpn2 <= wdata[31:13];

            if (tlbr)            hi_asid <= tin.asid;
            else if (we_entryhi) hi_asid <= wdata[7:0];

            if (tlbr) begin
                entrylo0 <= {4'b0, tin.lo0, tin.g};
                entrylo1 <= {4'b0, tin.lo1, tin.g};
            end else begin
                if (we_lo0) entrylo0 <= wdata[29:0];
                if (we_lo1) entrylo1 <= wdata[29:0];
            end

            // A probe miss sets P but leaves the previous index in place.
            if (tlbp) begin
                index_p <= probe_miss;
                if (!probe_miss) index_val <= probe_index;
            end else if (we_index) begin
                index_val <= wdata[IDX_W-1:0];
            end

            if (we_wired)  wired <= wdata[IDX_W-1:0];
            if (we_config) k0    <= wdata[2:0];
        end
    end

    cp0_random_gen #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (wired),
        .wired_we (we_wired),
        .random   (cp0_random)
    );

    logic [7:0] cause_ip;
    assign cause_ip = {cause_ti, ip_hw, ip_sw};   // IP7 mirrors TI

    always_comb begin
        rdata = '0;
        case (raddr)
            CP0_INDEX:    rdata = {index_p, 31'(index_val)};
            CP0_RANDOM:   rdata = 32'(cp0_random);
            CP0_ENTRYLO0: rdata = {2'b0, entrylo0};
            CP0_ENTRYLO1: rdata = {2'b0, entrylo1};
            CP0_CONTEXT:  rdata = {ctx_pte, ctx_vpn2, 4'b0};
            CP0_WIRED:    rdata = 32'(wired);
            CP0_BADVADDR: rdata = badvaddr;
            CP0_COUNT:    rdata = count;
            CP0_ENTRYHI:  rdata = {hi_vpn2, 5'b0, hi_asid};
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status;
            CP0_CAUSE:    rdata = {cause_bd, cause_ti, 6'b0, cause_iv, 7'b0,
                                   cause_ip, 1'b0, exccode, 2'b0};
            CP0_EPC:      rdata = epc;
            CP0_PRID:     rdata = PRID_VAL;
            CP0_CONFIG:   rdata = {1'b1, 21'b0, 3'b001, 4'b0, k0};
            CP0_CONFIG1:  rdata = {1'b0, 6'(TLB_ENTRIES - 1), 25'b0};
            default:      rdata = '0;
        endcase
    end

    assign tout.vpn2     = hi_vpn2;
    assign tout.asid     = hi_asid;
    assign tout.g        = entrylo0[0] & entrylo1[0];
    assign tout.lo0      = entrylo0[25:1];
    assign tout.lo1      = entrylo1[25:1];
    assign tlb_entry_out = tout;

    assign cp0_index      = index_val;
    assign curr_asid      = hi_asid;
    assign user_mode      = (status[4:1] == 4'b1000);
    assign kseg0_uncached = (k0 == 3'd2);
    assign exl            = status[ST_EXL];
    assign epc_address    = epc;
    assign int_pending    = status[ST_IE] & ~status[ST_EXL] & ~status[ST_ERL]
                          & |(status[15:8] & cause_ip);

endmodule

// File: tb/tb_cp0_tlb_timer.sv
// Self-checking bench for cp0_tlb_timer (TLB_ENTRIES=16, COUNT_DIV=2).
// A behavioural model tracks the register file from the rules of the block
// (Count as base + elapsed/COUNT_DIV, Random as a closed-form function of
// cycles since reload); a negedge process compares every output against it,
// and the directed sequence adds hand-computed literal expectations.
module tb_cp0_tlb_timer;
    import cp0_pkg::*;

    localparam int          N    = 16;
    localparam int          IW   = 4;
    localparam int          DIV  = 2;
    localparam logic [31:0] PRID = 32'h0001_8000;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    hint;
    logic [7:0]    raddr, waddr;
    logic [31:0]   rdata, wdata;
    logic          wen, exp_en, exp_bd, exp_badvaddr_en, eret, tlbr, tlbp, probe_miss;
    logic [4:0]    exp_code;
    logic [31:0]   exp_epc, exp_badvaddr, epc_address;
    logic [IW-1:0] probe_index, cp0_index, cp0_random;
    logic [77:0]   tlb_entry_in, tlb_entry_out;
    logic [7:0]    curr_asid;
    logic          user_mode, kseg0_uncached, exl, int_pending;

    always #5 clk = ~clk;

    cp0_tlb_timer #(
        .TLB_ENTRIES (N),
        .COUNT_DIV   (DIV),
        .PRID_VAL    (PRID)
    ) dut (.*);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_valid = 1'b0;
    logic          m_p;
    logic [IW-1:0] m_index, m_wired;
    int            m_rk;              // cycles since Random reload
    logic [29:0]   m_lo0, m_lo1;
    logic [8:0]    m_pte;
    logic [18:0]   m_ctxvpn, m_vpn2;
    logic [7:0]    m_asid;
    logic [31:0]   m_badv, m_cbase, m_compare, m_status, m_epc;
    int            m_ck;              // core cycles since Count was loaded
    logic          m_bd, m_ti, m_iv;
    logic [1:0]    m_ipsw;
    logic [4:0]    m_hintq, m_exc;
    logic [2:0]    m_k0;

    function automatic int exp_random();
        if (m_wired >= IW'(N - 1)) return N - 1;
        return N - 1 - (m_rk % (N - int'(m_wired)));
    endfunction

    function automatic logic [31:0] m_count();
        return m_cbase + 32'(m_ck / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_ti, m_hintq, m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            CP0_INDEX:    return {m_p, 27'b0, m_index};
            CP0_RANDOM:   return 32'(exp_random());
            CP0_ENTRYLO0: return {2'b0, m_lo0};
            CP0_ENTRYLO1: return {2'b0, m_lo1};
            CP0_CONTEXT:  return {m_pte, m_ctxvpn, 4'b0};
            CP0_WIRED:    return {28'b0, m_wired};
            CP0_BADVADDR: return m_badv;
            CP0_COUNT:    return m_count();
            CP0_ENTRYHI:  return {m_vpn2, 5'b0, m_asid};
            CP0_COMPARE:  return m_compare;
            CP0_STATUS:   return m_status;
            CP0_CAUSE:    return {m_bd, m_ti, 6'b0, m_iv, 7'b0, m_ip(), 1'b0, m_exc, 2'b0};
            CP0_EPC:      return m_epc;
            CP0_PRID:     return PRID;
            CP0_CONFIG:   return {1'b1, 21'b0, 3'b001, 4'b0, m_k0};
            CP0_CONFIG1:  return {1'b0, 6'(N - 1), 25'b0};
            default:      return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_p = 0; m_index = 0; m_wired = 0; m_rk = 0; m_lo0 = 0; m_lo1 = 0;
        m_pte = 0; m_ctxvpn = 0; m_vpn2 = 0; m_asid = 0; m_badv = 0;
        m_cbase = 0; m_ck = 0; m_compare = 0; m_status = 32'h1040_0004;
        m_epc = 0; m_bd = 0; m_ti = 0; m_iv = 0; m_ipsw = 0; m_hintq = 0;
        m_exc = 0; m_k0 = 0;
    endtask

    task automatic model_step();
        logic        old_exl = m_status[1];
        logic        old_erl = m_status[2];
        logic [31:0] old_cmp = m_compare;
        tlb_entry_t  e = tlb_entry_t'(tlb_entry_in);

        m_hintq = hint;

        if (wen && waddr == CP0_COUNT) begin
            m_cbase = wdata;
            m_ck    = 0;
        end else begin
            m_ck++;
            if ((m_ck % DIV == 0) && (m_count() == old_cmp)) m_ti = 1;
        end
        if (wen && waddr == CP0_COMPARE) begin
            m_compare = wdata;
            m_ti      = 0;
        end

        if (wen && waddr == CP0_WIRED) begin
            m_wired = wdata[IW-1:0];
            m_rk    = 0;
        end else begin
            m_rk++;
        end

        if (wen && waddr == CP0_STATUS) m_status = wdata & 32'h1040_FF17;
        if (eret) begin
            if (old_erl) m_status[2] = 0;
            else         m_status[1] = 0;
        end
        if (wen && waddr == CP0_CAUSE) begin
            m_iv   = wdata[23];
            m_ipsw = wdata[9:8];
        end
        if (wen && waddr == CP0_CONTEXT) m_pte = wdata[31:23];
        if (wen && waddr == CP0_CONFIG)  m_k0  = wdata[2:0];

        if (exp_en) begin
            if (!old_exl) begin
                m_epc = exp_epc;
                m_bd  = exp_bd;
            end
            m_exc       = exp_code;
            m_status[1] = 1;
        end else if (wen && waddr == CP0_EPC) begin
            m_epc = wdata;
        end

        if (wen && waddr == CP0_ENTRYHI) begin
            m_vpn2 = wdata[31:13];
            m_asid = wdata[7:0];
        end
        if (wen && waddr == CP0_ENTRYLO0) m_lo0 = wdata[29:0];
        if (wen && waddr == CP0_ENTRYLO1) m_lo1 = wdata[29:0];
        if (tlbr) begin
            m_vpn2 = e.vpn2;
            m_asid = e.asid;
            m_lo0  = {4'b0, e.lo0, e.g};
            m_lo1  = {4'b0, e.lo1, e.g};
        end
        if (exp_en && exp_badvaddr_en) begin
            m_badv   = exp_badvaddr;
            m_ctxvpn = exp_badvaddr[31:13];
            m_vpn2   = exp_badvaddr[31:13];
        end

        if (tlbp) begin
            m_p = probe_miss;
            if (!probe_miss) m_index = probe_index;
        end else if (wen && waddr == CP0_INDEX) begin
            m_index = wdata[IW-1:0];
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("random",      cp0_random, exp_random());
            check("exl",         exl, m_status[1]);
            check("epc",         epc_address, m_epc);
            check("index",       cp0_index, m_index);
            check("asid",        curr_asid, m_asid);
            check("user_mode",   user_mode, m_status[4:1] == 4'b1000);
            check("kseg0_unc",   kseg0_uncached, m_k0 == 3'd2);
            check("int_pending", int_pending,
                  m_status[0] & ~m_status[1] & ~m_status[2] & |(m_status[15:8] & m_ip()));
            check("entry_out",   tlb_entry_out,
                  {m_vpn2, m_asid, m_lo0[0] & m_lo1[0], m_lo0[25:1], m_lo1[25:1]});
            check("rdata",       rdata, m_read(raddr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [31:0] d);
        wen = 1; waddr = a; wdata = d;
        step();
        wen = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [77:0] entry;

        rst = 1; hint = 0; raddr = 0; waddr = 0; wdata = 0; wen = 0;
        exp_en = 0; exp_code = 0; exp_bd = 0; exp_epc = 0;
        exp_badvaddr_en = 0; exp_badvaddr = 0; eret = 0; tlbr = 0; tlbp = 0;
        probe_miss = 0; probe_index = 0; tlb_entry_in = 0;
        step(); step();
        rst = 0;

        // Reset state
        rd(CP0_STATUS, v);  check("rst_status", v, 32'h1040_0004);
        rd(CP0_CONFIG1, v); check("rst_mmusize", v[30:25], 6'd15);
        rd(CP0_CONFIG, v);  check("rst_config", v, 32'h8000_0080);
        check("rst_random", cp0_random, 4'd15);
        check("rst_intp", int_pending, 1'b0);
        check("rst_exl", exl, 1'b0);

        // Timer: Count ticks every 2 cycles, reaches 10 on cycle 20
        write(CP0_COMPARE, 32'd10);
        write(CP0_STATUS, 32'h1040_8001);
        repeat (17) step();
        rd(CP0_COUNT, v);   check("count_c19", v, 32'd9);
        check("intp_c19", int_pending, 1'b0);
        step();
        rd(CP0_COUNT, v);   check("count_c20", v, 32'd10);
        rd(CP0_CAUSE, v);   check("ti_c20", v[30], 1'b1);
        check("intp_c20", int_pending, 1'b1);
        write(CP0_COMPARE, 32'h100);
        rd(CP0_CAUSE, v);   check("ti_cleared", v[30], 1'b0);
        check("intp_cleared", int_pending, 1'b0);

        // Compare write coinciding with a match: clear wins
        write(CP0_COUNT, 32'hFF);
        step();
        write(CP0_COMPARE, 32'h100);
        rd(CP0_COUNT, v);   check("count_coinc", v, 32'h100);
        rd(CP0_CAUSE, v);   check("ti_coinc", v[30], 1'b0);

        // Compare=0 matches on the 32-bit wrap
        write(CP0_COMPARE, 32'h0);
        write(CP0_COUNT, 32'hFFFF_FFFF);
        step();
        rd(CP0_CAUSE, v);   check("ti_prewrap", v[30], 1'b0);
        step();
        rd(CP0_COUNT, v);   check("count_wrap", v, 32'h0);
        rd(CP0_CAUSE, v);   check("ti_wrap", v[30], 1'b1);
        write(CP0_COMPARE, 32'h8000_0000);

        // Random with Wired=3: 15..3 then 15, period 13
        write(CP0_WIRED, 32'd3);
        check("rand_reload", cp0_random, 4'd15);
        repeat (12) step();
        check("rand_floor", cp0_random, 4'd3);
        step();
        check("rand_wrap", cp0_random, 4'd15);

        // Hardware interrupt lines, one cycle of latency
        hint = 5'h15;
        step();
        hint = 5'h00;
        rd(CP0_CAUSE, v);   check("cause_hint", v[14:10], 5'h15);
        rd(8'h38, v);       check("unmapped_r7", v, 32'h0);
        rd(8'h61, v);       check("unmapped_st1", v, 32'h0);

        // Nested exceptions keep the first EPC/BD
        exp_en = 1; exp_epc = 32'h8000_1000; exp_bd = 1; exp_code = EXC_SYS;
        step();
        exp_epc = 32'h8000_2000; exp_bd = 0; exp_code = EXC_BP;
        step();
        exp_en = 0;
        check("epc_nested", epc_address, 32'h8000_1000);
        check("model_epc", m_epc, 32'h8000_1000);
        check("exl_set", exl, 1'b1);
        rd(CP0_CAUSE, v);   check("bd_kept", v[31], 1'b1);
        check("exccode", v[6:2], 5'd9);
        eret = 1;
        step();
        eret = 0;
        check("exl_eret", exl, 1'b0);

        // wen to EntryHi together with a BadVAddr-loading exception
        wen = 1; waddr = CP0_ENTRYHI; wdata = 32'h1234_5000;
        exp_en = 1; exp_badvaddr_en = 1; exp_badvaddr = 32'hABCD_E000;
        exp_epc = 32'h8000_3000; exp_code = EXC_TLBL;
        step();
        wen = 0; exp_en = 0; exp_badvaddr_en = 0;
        rd(CP0_ENTRYHI, v);  check("entryhi_prio", v, 32'hABCD_E000);
        rd(CP0_BADVADDR, v); check("badvaddr", v, 32'hABCD_E000);
        rd(CP0_CONTEXT, v);  check("context_vpn2", v, 32'h0055_E6F0);
        eret = 1;
        step();
        eret = 0;

        // TLB probe and read
        write(CP0_INDEX, 32'd5);
        tlbp = 1; probe_miss = 1; probe_index = 4'd9;
        step();
        rd(CP0_INDEX, v);   check("tlbp_miss", v, 32'h8000_0005);
        probe_miss = 0; probe_index = 4'd7;
        step();
        tlbp = 0;
        rd(CP0_INDEX, v);   check("tlbp_hit", v, 32'h0000_0007);
        entry = {19'h4_5678, 8'h3C, 1'b1, 25'h0AB_CDE7, 25'h123_4567};
        tlb_entry_in = entry;
        tlbr = 1;
        step();
        tlbr = 0;
        check("tlbr_entry", tlb_entry_out, entry);
        check("tlbr_asid", curr_asid, 8'h3C);
        rd(CP0_ENTRYLO0, v); check("tlbr_lo0", v, 32'h0157_9BCF);
        write(CP0_ENTRYLO1, 32'h0000_0002);
        check("g_and", tlb_entry_out[50], 1'b0);
        check("lo1_field", tlb_entry_out[24:0], 25'h1);

        // Mode outputs and Status write mask
        write(CP0_CONFIG, 32'd2);
        check("kseg0_unc", kseg0_uncached, 1'b1);
        write(CP0_STATUS, 32'hFFFF_FFFF);
        rd(CP0_STATUS, v);  check("status_mask", v, 32'h1040_FF17);
        check("user_off", user_mode, 1'b0);
        write(CP0_STATUS, 32'h0000_0010);
        check("user_on", user_mode, 1'b1);

        // Reset in the middle of operation
        rst = 1;
        step();
        rst = 0;
        rd(CP0_STATUS, v);  check("rst2_status", v, 32'h1040_0004);
        rd(CP0_COUNT, v);   check("rst2_count", v, 32'h0);
        check("rst2_random", cp0_random, 4'd15);
        check("rst2_k0", kseg0_uncached, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
